core_ldst_mult_seq: RTL and testbench

CORE_LDST_MULT_SEQ -- requirements
Module: core_ldst_mult_seq

---
 rtl/core_ldst_mult_seq_pkg.sv | 25 ++
 rtl/core_ldst_mult_pick.sv | 22 ++
 rtl/core_ldst_mult_seq.sv | 166 ++++++++++++++++
 tb/tb_core_ldst_mult_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ldst_mult_seq_pkg.sv
// Shared types for the load/store-multiple sequencer: word/register typedefs,
// FSM state encoding and a list popcount helper.
package core_ldst_mult_seq_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  reg_num_t;
  typedef logic [15:0] reg_list_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam word_t WORD_BYTES = 32'd4;

  function automatic logic [4:0] popcount16(input reg_list_t list);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + {4'd0, list[i]};
    return cnt;
  endfunction

endpackage

// File: rtl/core_ldst_mult_pick.sv
// Lowest-set-bit picker: selects the next register of a transfer list and
// flags when it is the only one left.
module core_ldst_mult_pick
  import core_ldst_mult_seq_pkg::*;
(
  input  reg_list_t i_list,
  output reg_num_t  o_reg,
  output logic      o_valid,
  output logic      o_last
);

  always_comb begin
    o_reg = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i_list[i]) o_reg = reg_num_t'(i);
    end
  end

  assign o_valid = |i_list;
  assign o_last  = o_valid && ((i_list & (i_list - 16'd1)) == 16'd0);

endmodule

// File: rtl/core_ldst_mult_seq.sv
// Load/store-multiple beat sequencer (IA/IB/DA/DB, abortable).
// Optional: CORE_LDST_MULT_EMPTY_LIST_EN makes an empty list transfer r15 with n = 16.
module core_ldst_mult_seq
  import core_ldst_mult_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  input  reg_list_t reg_list,
  input  word_t     base,
  input  logic      increment,
  input  logic      pre_index,
  input  logic      load,
  input  logic      req_ready,
  input  logic      abort,
  output logic      busy,
  output logic      req_valid,
  output word_t     req_addr,
  output reg_num_t  req_reg,
  output logic      req_load,
  output logic      req_last,
  output word_t     wb_value,
  output logic      done,
  output logic      aborted,
  output state_t    dbg_state
);

  // Handshake: a beat transfers on a rising edge where req_valid & req_ready & !abort;
  // abort with req_valid high ends the sequence regardless of req_ready.

  state_t    r_state;
  reg_list_t r_list;
  word_t     r_base;
  word_t     r_addr;
  word_t     r_wb;
  logic      r_inc;
  logic      r_pre;
  logic      r_load;
  logic      r_busy;
  logic      r_valid;
  logic      r_done;
  logic      r_aborted;
`ifdef CORE_LDST_MULT_EMPTY_LIST_EN
  logic      r_empty;
`endif

  reg_num_t  w_pick_reg;
  logic      w_pick_valid;
  logic      w_pick_last;
  logic [4:0] w_n;
  word_t     w_four_n;
  word_t     w_first_addr;
  word_t     w_wb;
  logic      w_accept;

  core_ldst_mult_pick u_pick (
    .i_list  (r_list),
    .o_reg   (w_pick_reg),
    .o_valid (w_pick_valid),
    .o_last  (w_pick_last)
  );

`ifdef CORE_LDST_MULT_EMPTY_LIST_EN
  assign w_n = r_empty ? 5'd16 : popcount16(r_list);
`else
  assign w_n = popcount16(r_list);
`endif

  assign w_four_n = {25'd0, w_n, 2'b00};

  // Beats always walk upward, so descending modes start at the bottom of the block.
  always_comb begin
    w_first_addr = r_base;
    if (r_inc) w_first_addr = r_pre ? r_base + WORD_BYTES : r_base;
    else       w_first_addr = r_pre ? r_base - w_four_n : r_base - w_four_n + WORD_BYTES;
  end

  assign w_wb     = r_inc ? r_base + w_four_n : r_base - w_four_n;
  assign w_accept = r_valid && w_pick_valid && req_ready && !abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_list    <= '0;
      r_base    <= '0;
      r_addr    <= '0;
      r_wb      <= '0;
      r_inc     <= 1'b0;
      r_pre     <= 1'b0;
      r_load    <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
`ifdef CORE_LDST_MULT_EMPTY_LIST_EN
      r_empty   <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= base;
            r_inc   <= increment;
            r_pre   <= pre_index;
            r_load  <= load;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
`ifdef CORE_LDST_MULT_EMPTY_LIST_EN
            r_list  <= (reg_list == 16'd0) ? 16'h8000 : reg_list;
            r_empty <= (reg_list == 16'd0);
`else
            r_list  <= reg_list;
`endif
          end
        end
        S_SETUP: begin
          r_addr <= w_first_addr & 32'hFFFF_FFFC;
          r_wb   <= w_wb;
          if (w_n == 5'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_XFER;
            r_valid <= 1'b1;
          end
        end
        S_XFER: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
            r_list    <= '0;
          end else if (w_accept) begin
            r_list <= r_list & (r_list - 16'd1);
            r_addr <= r_addr + WORD_BYTES;
            if (w_pick_last) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign req_valid = r_valid;
  assign req_addr  = r_addr;
  assign req_reg   = w_pick_reg;
  assign req_load  = r_load;
  assign req_last  = w_pick_last & r_valid;
  assign wb_value  = r_wb;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_core_ldst_mult_seq.sv
// Bench for core_ldst_mult_seq: directed and random load/store-multiple runs
// checked against a beat-list reference model.
module tb_core_ldst_mult_seq;
  import core_ldst_mult_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base;
  logic        increment;
  logic        pre_index;
  logic        load;
  logic        req_ready;
  logic        abort;
  logic        busy;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_reg;
  logic        req_load;
  logic        req_last;
  logic [31:0] wb_value;
  logic        done;
  logic        aborted;
  state_t      dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  core_ldst_mult_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .reg_list  (reg_list),
    .base      (base),
    .increment (increment),
    .pre_index (pre_index),
    .load      (load),
    .req_ready (req_ready),
    .abort     (abort),
    .busy      (busy),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_reg   (req_reg),
    .req_load  (req_load),
    .req_last  (req_last),
    .wb_value  (wb_value),
    .done      (done),
    .aborted   (aborted),
    .dbg_state (dbg_state)
  );

  // Reference: list of {reg, addr} beats in issue order plus the written-back base.
  task automatic model_seq(input logic [15:0] list, input logic [31:0] b, input logic inc,
                           input logic pre, output logic [31:0] wb, output int n);
    logic [15:0] eff;
    logic [31:0] a;
    logic [31:0] top;
    eff = list;
    n = 0;
    for (int r = 0; r < 16; r++) if (list[r]) n++;
`ifdef CORE_LDST_MULT_EMPTY_LIST_EN
    if (list == 16'h0) begin
      eff = 16'h8000;
      n = 16;
    end
`endif
    if (inc) begin
      a = pre ? b + 32'd4 : b;
      wb = b + 32'(4 * n);
    end else begin
      top = pre ? b - 32'd4 : b;
      a = top - 32'(4 * (n - 1));
      wb = b - 32'(4 * n);
    end
    exp_q.delete();
    for (int r = 0; r < 16; r++) begin
      if (eff[r]) begin
        exp_q.push_back({4'(r), a & 32'hFFFF_FFFC});
        a = a + 32'd4;
      end
    end
  endtask

  task automatic do_sequence(input logic [15:0] list, input logic [31:0] b, input logic inc,
                             input logic pre, input logic ld, input int stall_first,
                             input int stall_pct, input int abort_beat, input int rst_beat);
    logic [31:0] exp_wb;
    logic [35:0] got;
    logic [35:0] held_beat;
    int n, cyc, beat, stalls, abort_cyc, stall_left;
    bit held, fin;
    model_seq(list, b, inc, pre, exp_wb, n);
    @(negedge clk);
    start = 1'b1; reg_list = list; base = b; increment = inc; pre_index = pre; load = ld;
    req_ready = 1'b0; abort = 1'b0;
    @(negedge clk);
    reg_list = 16'($urandom); base = $urandom; increment = 1'($urandom);
    pre_index = 1'($urandom); load = 1'($urandom);
    cyc = 1; beat = 0; stalls = 0; abort_cyc = -1; held = 0; fin = 0; stall_left = stall_first;
    held_beat = '0;
    while (!fin && cyc < 300) begin
      start = 1'b0;
      abort = 1'b0;
      req_ready = 1'($urandom);
      if (abort_cyc >= 0) begin
        vectors++;
        if (aborted !== 1'b1 || busy !== 1'b0 || req_valid !== 1'b0 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_end: got aborted=%b busy=%b valid=%b done=%b, expected 1 0 0 0",
                   aborted, busy, req_valid, done);
        end
        fin = 1;
      end else if (done === 1'b1) begin
        vectors++;
        if (exp_q.size() != 0 || cyc != n + 2 + stalls || wb_value !== exp_wb || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL done: got cycle=%0d wb=%h busy=%b left=%0d, expected cycle=%0d wb=%h busy=1 left=0",
                   cyc, wb_value, busy, exp_q.size(), n + 2 + stalls, exp_wb);
        end
        fin = 1;
      end else if (req_valid === 1'b1) begin
        got = {req_reg, req_addr};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_beat: got reg=%0d addr=%h, expected no beat", req_reg, req_addr);
        end else if (got !== exp_q[0] || req_last !== 1'(exp_q.size() == 1) || req_load !== ld ||
                     wb_value !== exp_wb || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL beat%0d: got reg=%0d addr=%h last=%b load=%b wb=%h, expected reg=%0d addr=%h last=%b load=%b wb=%h",
                   beat, req_reg, req_addr, req_last, req_load, wb_value, exp_q[0][35:32],
                   exp_q[0][31:0], exp_q.size() == 1, ld, exp_wb);
        end
        if (held) begin
          vectors++;
          if (got !== held_beat) begin
            miscompares++;
            $display("FAIL stall_hold: got %h, expected %h", got, held_beat);
          end
        end
        if (beat == rst_beat) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          vectors++;
          if (req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 ||
              req_addr !== 32'd0 || req_reg !== 4'd0 || wb_value !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got valid=%b busy=%b done=%b aborted=%b addr=%h reg=%0d wb=%h, expected all 0",
                     req_valid, busy, done, aborted, req_addr, req_reg, wb_value);
          end
          exp_q.delete();
          return;
        end
        if (beat == abort_beat) begin
          abort = 1'b1;
          abort_cyc = cyc;
        end else begin
          if (stall_left > 0) begin
            req_ready = 1'b0;
            stall_left--;
          end else begin
            req_ready = ($urandom_range(0, 99) >= stall_pct);
          end
          if (req_ready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            beat++;
            held = 0;
          end else begin
            stalls++;
            held = 1;
            held_beat = got;
          end
        end
      end else begin
        vectors++;
        if (cyc != 1 || busy !== 1'b1 || aborted !== 1'b0) begin
          miscompares++;
          $display("FAIL no_beat: got cycle=%0d busy=%b aborted=%b, expected cycle=1 busy=1 aborted=0",
                   cyc, busy, aborted);
        end
        abort = ($urandom_range(0, 1) == 0);
      end
      if (!fin && busy === 1'b1) start = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL timeout: got no done/aborted in %0d cycles, expected completion", cyc);
    end else if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_idle: got busy=%b done=%b aborted=%b valid=%b, expected 0 0 0 0",
               busy, done, aborted, req_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; reg_list = 16'hFFFF; base = 32'hDEAD_BEEF;
    increment = 1'b1; pre_index = 1'b1; load = 1'b1; req_ready = 1'b1; abort = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || req_valid !== 1'b0 || req_last !== 1'b0 || done !== 1'b0 ||
        aborted !== 1'b0 || req_addr !== 32'd0 || req_reg !== 4'd0 || wb_value !== 32'd0) begin
      miscompares++;
      $display("FAIL reset: got busy=%b valid=%b last=%b done=%b aborted=%b addr=%h reg=%0d wb=%h, expected all 0",
               busy, req_valid, req_last, done, aborted, req_addr, req_reg, wb_value);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_ia();
    do_sequence(16'h000F, 32'h1000, 1'b1, 1'b0, 1'b1, 0, 0, -1, -1);
  endtask

  task automatic test_db();
    do_sequence(16'h8001, 32'h2000, 1'b0, 1'b1, 1'b0, 0, 0, -1, -1);
  endtask

  task automatic test_ib_stall();
    do_sequence(16'h0010, 32'h3000, 1'b1, 1'b1, 1'b1, 3, 0, -1, -1);
  endtask

  task automatic test_da_abort();
    do_sequence(16'h0007, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 0, 0, 1, -1);
  endtask

  task automatic test_empty();
    do_sequence(16'h0000, 32'h40, 1'b1, 1'b0, 1'b0, 0, 0, -1, -1);
  endtask

  task automatic test_reset_mid();
    do_sequence(16'h00FF, 32'h5000, 1'b1, 1'b0, 1'b0, 0, 0, -1, 1);
    do_sequence(16'h00FF, 32'h5000, 1'b1, 1'b0, 1'b0, 0, 0, -1, -1);
  endtask

  task automatic test_wrap();
    do_sequence(16'hFFFF, 32'h0000_0004, 1'b0, 1'b1, 1'b1, 0, 0, -1, -1);
    do_sequence(16'hFFFF, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 0, 20, -1, -1);
    do_sequence(16'h0A05, 32'h0000_1003, 1'b1, 1'b1, 1'b0, 0, 0, -1, -1);
  endtask

  task automatic test_random();
    logic [15:0] l;
    for (int k = 0; k < 30; k++) begin
      l = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
      do_sequence(l, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2),
                  $urandom_range(0, 50),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1, -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++)
      do_sequence(16'($urandom) | 16'h1, $urandom, 1'($urandom), 1'($urandom), 1'b1, 0, 0, -1, -1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; reg_list = '0; base = '0; increment = 1'b0;
    pre_index = 1'b0; load = 1'b0; req_ready = 1'b0; abort = 1'b0;
    test_reset();
    test_ia();
    test_db();
    test_ib_stall();
    test_da_abort();
    test_empty();
    test_reset_mid();
    test_wrap();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
